// File: rtl/mem_arb_pkg.sv
// Shared types for the mem_arbiter slice: grant encoding and response FSM states.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } gnt_t;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_VALID = 1'b1
  } rsp_state_t;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of client request/response channels plus the mem-side bus of mem_arbiter.
// slave is the arbiter's view; master is the client/memory environment's view.
interface mem_arb_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_ADR    = 100,
  parameter int ADDRSIZE   = $clog2(MAX_ADR)
);

  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDRSIZE-1:0]   rd_req_addr;
  logic                  rd_rsp_valid;
  logic                  rd_rsp_ready;
  logic [DATA_WIDTH-1:0] rd_rsp_data;
  logic                  wr_req_valid;
  logic                  wr_req_ready;
  logic [ADDRSIZE-1:0]   wr_req_addr;
  logic [DATA_WIDTH-1:0] wr_req_data;
  logic                  mem_rd_en;
  logic [ADDRSIZE-1:0]   mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  mem_wr_en;
  logic [ADDRSIZE-1:0]   mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic                  err;

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_rsp_ready,
    input  wr_req_valid, wr_req_addr, wr_req_data,
    input  mem_rd_data,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data,
    output wr_req_ready,
    output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    output err
  );

  modport master (
    output rd_req_valid, rd_req_addr, rd_rsp_ready,
    output wr_req_valid, wr_req_addr, wr_req_data,
    output mem_rd_data,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data,
    input  wr_req_ready,
    input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  err
  );

endinterface

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker between read and write eligibles.
// On a conflict the side opposite to the last grant wins; last grant resets to write.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rd_elig,
  input  logic wr_elig,
  output gnt_t gnt
);

  gnt_t last_gnt_r;
  gnt_t gnt_s;

  // Pick a winner from the eligibles and the last grant.
  always_comb begin
    gnt_s = GNT_NONE;
    if (rd_elig && wr_elig) begin
      if (last_gnt_r == GNT_RD) begin
        gnt_s = GNT_WR;
      end else begin
        gnt_s = GNT_RD;
      end
    end else if (rd_elig) begin
      gnt_s = GNT_RD;
    end else if (wr_elig) begin
      gnt_s = GNT_WR;
    end else begin
      gnt_s = GNT_NONE;
    end
  end

  // Remember the most recent grant; idle cycles leave it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_r <= GNT_WR;
    end else if (gnt_s != GNT_NONE) begin
      last_gnt_r <= gnt_s;
    end else begin
      last_gnt_r <= last_gnt_r;
    end
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises read/write request streams onto a single mem instance with a
// backpressurable read-response channel. Define MEM_ARB_WR_PRIO_EN for fixed write priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_ADR    = 100,
  parameter int ADDRSIZE   = $clog2(MAX_ADR)
) (
  input logic      clk,
  input logic      rst,
  mem_arb_if.slave bus
);

  // One extra bit so MAX_ADR itself is representable when it is a power of two.
  localparam logic [ADDRSIZE:0] ADR_LIMIT = (ADDRSIZE+1)'(MAX_ADR);

  rsp_state_t rsp_state_r;
  rsp_state_t rsp_state_nxt_s;
  gnt_t       gnt_s;

  logic rd_elig_s;
  logic wr_elig_s;
  logic rd_oor_s;
  logic wr_oor_s;
  logic oor_r;
  logic err_r;

  logic                  rd_req_ready_s;
  logic                  wr_req_ready_s;
  logic                  mem_rd_en_s;
  logic [ADDRSIZE-1:0]   mem_rd_addr_s;
  logic                  mem_wr_en_s;
  logic [ADDRSIZE-1:0]   mem_wr_addr_s;
  logic [DATA_WIDTH-1:0] mem_wr_data_s;

  // A read may only issue if the response slot is free or drains this cycle.
  assign rd_elig_s = bus.rd_req_valid && ((rsp_state_r == RSP_EMPTY) || bus.rd_rsp_ready);
  assign wr_elig_s = bus.wr_req_valid;
  assign rd_oor_s  = ({1'b0, bus.rd_req_addr} >= ADR_LIMIT);
  assign wr_oor_s  = ({1'b0, bus.wr_req_addr} >= ADR_LIMIT);

`ifdef MEM_ARB_WR_PRIO_EN
  // Fixed priority: a pending write always beats a read.
  always_comb begin
    gnt_s = GNT_NONE;
    if (wr_elig_s) begin
      gnt_s = GNT_WR;
    end else if (rd_elig_s) begin
      gnt_s = GNT_RD;
    end else begin
      gnt_s = GNT_NONE;
    end
  end
`else
  mem_arb_rr u_rr (
    .clk     (clk),
    .rst     (rst),
    .rd_elig (rd_elig_s),
    .wr_elig (wr_elig_s),
    .gnt     (gnt_s)
  );
`endif

  // Turn the grant into handshakes and the mem drive; out-of-range accesses are consumed silently.
  always_comb begin
    rd_req_ready_s = 1'b0;
    wr_req_ready_s = 1'b0;
    mem_rd_en_s    = 1'b0;
    mem_rd_addr_s  = {ADDRSIZE{1'b0}};
    mem_wr_en_s    = 1'b0;
    mem_wr_addr_s  = {ADDRSIZE{1'b0}};
    mem_wr_data_s  = {DATA_WIDTH{1'b0}};
    case (gnt_s)
      GNT_RD: begin
        rd_req_ready_s = 1'b1;
        if (!rd_oor_s) begin
          mem_rd_en_s   = 1'b1;
          mem_rd_addr_s = bus.rd_req_addr;
        end else begin
          mem_rd_en_s   = 1'b0;
        end
      end
      GNT_WR: begin
        wr_req_ready_s = 1'b1;
        if (!wr_oor_s) begin
          mem_wr_en_s   = 1'b1;
          mem_wr_addr_s = bus.wr_req_addr;
          mem_wr_data_s = bus.wr_req_data;
        end else begin
          mem_wr_en_s   = 1'b0;
        end
      end
      default: begin
        rd_req_ready_s = 1'b0;
        wr_req_ready_s = 1'b0;
      end
    endcase
  end

  // Response slot next-state: a new read refills it, an accept without a new read empties it.
  always_comb begin
    rsp_state_nxt_s = rsp_state_r;
    case (rsp_state_r)
      RSP_EMPTY: begin
        if (gnt_s == GNT_RD) begin
          rsp_state_nxt_s = RSP_VALID;
        end else begin
          rsp_state_nxt_s = RSP_EMPTY;
        end
      end
      RSP_VALID: begin
        if (gnt_s == GNT_RD) begin
          rsp_state_nxt_s = RSP_VALID;
        end else if (bus.rd_rsp_ready) begin
          rsp_state_nxt_s = RSP_EMPTY;
        end else begin
          rsp_state_nxt_s = RSP_VALID;
        end
      end
      default: begin
        rsp_state_nxt_s = RSP_EMPTY;
      end
    endcase
  end

  // Response state, out-of-range tag for the held response, and the error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_state_r <= RSP_EMPTY;
      oor_r       <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      rsp_state_r <= rsp_state_nxt_s;
      if (gnt_s == GNT_RD) begin
        oor_r <= rd_oor_s;
      end else begin
        oor_r <= oor_r;
      end
      err_r <= ((gnt_s == GNT_RD) && rd_oor_s) || ((gnt_s == GNT_WR) && wr_oor_s);
    end
  end

  assign bus.rd_req_ready = rd_req_ready_s;
  assign bus.wr_req_ready = wr_req_ready_s;
  assign bus.mem_rd_en    = mem_rd_en_s;
  assign bus.mem_rd_addr  = mem_rd_addr_s;
  assign bus.mem_wr_en    = mem_wr_en_s;
  assign bus.mem_wr_addr  = mem_wr_addr_s;
  assign bus.mem_wr_data  = mem_wr_data_s;
  assign bus.rd_rsp_valid = (rsp_state_r == RSP_VALID);
  // mem keeps rd_data until its next read, so the response is stable under backpressure.
  assign bus.rd_rsp_data  = oor_r ? {DATA_WIDTH{1'b0}} : bus.mem_rd_data;
  assign bus.err          = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural mem model.
module tb_mem_arbiter;

`ifdef MEM_ARB_WR_PRIO_EN
  localparam logic RD_FIRST = 1'b0;
`else
  localparam logic RD_FIRST = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total_cnt = 0;
  int   bad_cnt   = 0;
  logic [7:0] mem_arr [0:127];

  mem_arb_if #(.DATA_WIDTH(8), .MAX_ADR(100)) bus ();

  mem_arbiter #(.DATA_WIDTH(8), .MAX_ADR(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // behavioural mem: registered read, write on the edge
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem_arr[bus.mem_wr_addr] <= bus.mem_wr_data;
    if (bus.mem_rd_en) bus.mem_rd_data <= mem_arr[bus.mem_rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    if (got !== exp) begin
      bad_cnt = bad_cnt + 1;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    bus.rd_req_valid = 1'b0;
    bus.rd_req_addr  = 7'd0;
    bus.rd_rsp_ready = 1'b1;
    bus.wr_req_valid = 1'b0;
    bus.wr_req_addr  = 7'd0;
    bus.wr_req_data  = 8'h00;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset with random inputs
    rst = 1'b1;
    bus.rd_req_valid = 1'($urandom_range(0, 1));
    bus.rd_req_addr  = 7'($urandom_range(0, 127));
    bus.rd_rsp_ready = 1'($urandom_range(0, 1));
    bus.wr_req_valid = 1'($urandom_range(0, 1));
    bus.wr_req_addr  = 7'($urandom_range(0, 127));
    bus.wr_req_data  = 8'($urandom_range(0, 255));
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", bus.rd_rsp_valid, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    set_idle();
    #1;
    chk("rst_rd_en", bus.mem_rd_en, 1'b0);
    chk("rst_wr_en", bus.mem_wr_en, 1'b0);
    chk("rst_rd_rdy", bus.rd_req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // conflict right after reset: read 5 vs write 6
    bus.rd_req_valid = 1'b1; bus.rd_req_addr = 7'd5;
    bus.wr_req_valid = 1'b1; bus.wr_req_addr = 7'd6; bus.wr_req_data = 8'h66;
    #1;
    chk("cf0_rd_rdy", bus.rd_req_ready, RD_FIRST);
    chk("cf0_wr_rdy", bus.wr_req_ready, !RD_FIRST);
    chk("cf0_both_en", bus.mem_rd_en & bus.mem_wr_en, 1'b0);
    @(negedge clk);
    if (RD_FIRST) bus.rd_req_valid = 1'b0;
    else          bus.wr_req_valid = 1'b0;
    #1;
    chk("cf1_rd_rdy", bus.rd_req_ready, !RD_FIRST);
    chk("cf1_wr_rdy", bus.wr_req_ready, RD_FIRST);
    chk("cf1_both_en", bus.mem_rd_en & bus.mem_wr_en, 1'b0);
    chk("cf1_rsp_valid", bus.rd_rsp_valid, RD_FIRST);
    @(negedge clk);
    set_idle();
    chk("cf2_rsp_valid", bus.rd_rsp_valid, !RD_FIRST);
    @(negedge clk);

    // write 5 <- A5, then read 5
    bus.wr_req_valid = 1'b1; bus.wr_req_addr = 7'd5; bus.wr_req_data = 8'hA5;
    #1;
    chk("wr5_rdy", bus.wr_req_ready, 1'b1);
    chk("wr5_en", bus.mem_wr_en, 1'b1);
    chk("wr5_data", bus.mem_wr_data, 8'hA5);
    @(negedge clk);
    set_idle();
    bus.rd_req_valid = 1'b1; bus.rd_req_addr = 7'd5;
    #1;
    chk("rd5_rdy", bus.rd_req_ready, 1'b1);
    chk("rd5_en", bus.mem_rd_en, 1'b1);
    chk("rd5_addr", bus.mem_rd_addr, 7'd5);
    @(negedge clk);
    bus.rd_req_valid = 1'b0;
    chk("rd5_rsp_valid", bus.rd_rsp_valid, 1'b1);
    chk("rd5_rsp_data", bus.rd_rsp_data, 8'hA5);
    @(negedge clk);
    chk("rd5_drained", bus.rd_rsp_valid, 1'b0);

    // backpressure: response from addr 5 held, writes to 7 keep flowing
    bus.rd_req_valid = 1'b1; bus.rd_req_addr = 7'd5; bus.rd_rsp_ready = 1'b0;
    @(negedge clk);
    bus.rd_req_addr = 7'd6;
    for (int i = 0; i < 3; i++) begin
      bus.wr_req_valid = 1'b1; bus.wr_req_addr = 7'd7; bus.wr_req_data = 8'(8'h70 + i);
      #1;
      chk("bp_rd_rdy", bus.rd_req_ready, 1'b0);
      chk("bp_wr_rdy", bus.wr_req_ready, 1'b1);
      chk("bp_wr_en", bus.mem_wr_en, 1'b1);
      chk("bp_rsp_valid", bus.rd_rsp_valid, 1'b1);
      chk("bp_rsp_data", bus.rd_rsp_data, 8'hA5);
      @(negedge clk);
    end
    // release: back-to-back read of 6 while the held response drains
    bus.wr_req_valid = 1'b0; bus.rd_rsp_ready = 1'b1;
    #1;
    chk("b2b_rd_rdy", bus.rd_req_ready, 1'b1);
    @(negedge clk);
    chk("b2b_rsp_valid", bus.rd_rsp_valid, 1'b1);
    chk("b2b_rsp_data", bus.rd_rsp_data, 8'h66);
    // last grant was a read, so this conflict goes to the write
    bus.rd_req_addr = 7'd7;
    bus.wr_req_valid = 1'b1; bus.wr_req_addr = 7'd8; bus.wr_req_data = 8'h88;
    #1;
    chk("rr_wr_rdy", bus.wr_req_ready, 1'b1);
    chk("rr_rd_rdy", bus.rd_req_ready, 1'b0);
    @(negedge clk);
    bus.wr_req_valid = 1'b0;
    #1;
    chk("rd7_rdy", bus.rd_req_ready, 1'b1);
    @(negedge clk);
    set_idle();
    chk("rd7_rsp_data", bus.rd_rsp_data, 8'h72);
    @(negedge clk);

    // out of range write 100
    bus.wr_req_valid = 1'b1; bus.wr_req_addr = 7'd100; bus.wr_req_data = 8'h11;
    #1;
    chk("oorw_rdy", bus.wr_req_ready, 1'b1);
    chk("oorw_en", bus.mem_wr_en, 1'b0);
    @(negedge clk);
    set_idle();
    chk("oorw_err", bus.err, 1'b1);
    @(negedge clk);
    chk("oorw_err_end", bus.err, 1'b0);
    // out of range read 127
    bus.rd_req_valid = 1'b1; bus.rd_req_addr = 7'd127;
    #1;
    chk("oorr_rdy", bus.rd_req_ready, 1'b1);
    chk("oorr_en", bus.mem_rd_en, 1'b0);
    @(negedge clk);
    set_idle();
    chk("oorr_err", bus.err, 1'b1);
    chk("oorr_rsp_valid", bus.rd_rsp_valid, 1'b1);
    chk("oorr_rsp_data", bus.rd_rsp_data, 8'h00);
    @(negedge clk);
    chk("oorr_err_end", bus.err, 1'b0);
    chk("oorr_drained", bus.rd_rsp_valid, 1'b0);

    // reset mid-operation with a pending response
    bus.rd_req_valid = 1'b1; bus.rd_req_addr = 7'd5; bus.rd_rsp_ready = 1'b0;
    @(negedge clk);
    bus.rd_req_valid = 1'b0;
    chk("mid_rsp_valid", bus.rd_rsp_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_async_drop", bus.rd_rsp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.rd_rsp_ready = 1'b1;
    bus.rd_req_valid = 1'b1; bus.rd_req_addr = 7'd5;
    bus.wr_req_valid = 1'b1; bus.wr_req_addr = 7'd9; bus.wr_req_data = 8'h99;
    #1;
    chk("mid_cf_rd_rdy", bus.rd_req_ready, RD_FIRST);
    chk("mid_cf_wr_rdy", bus.wr_req_ready, !RD_FIRST);
    @(negedge clk);
    set_idle();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester access controller for the single-clock `mem` block. It accepts independent read and write request streams with valid/ready handshakes, and serializes them so that `mem_rd_en` and `mem_wr_en` are never high together (`mem` performs no access when both are high). It returns read data through a backpressurable response channel and flags out-of-range addresses. It sits between client logic and one `mem` instance, with parameters matching that instance.

## Interface
- `DATA_WIDTH`, default 8: memory word width.
- `MAX_ADR`, default 100: number of words; valid addresses are 0..MAX_ADR-1.
- `ADDRSIZE`, default `$clog2(MAX_ADR)`: address width.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: reset, asynchronous and active-high.
- `rd_req_valid` in 1: read request present.
- `rd_req_ready` out 1: read request accepted this cycle.
- `rd_req_addr` in ADDRSIZE: read address.
- `rd_rsp_valid` out 1: read response present.
- `rd_rsp_ready` in 1: consumer accepts response.
- `rd_rsp_data` out DATA_WIDTH: read data.
- `wr_req_valid` in 1: write request present.
- `wr_req_ready` out 1: write request accepted this cycle.
- `wr_req_addr` in ADDRSIZE: write address.
- `wr_req_data` in DATA_WIDTH: write data.
- `mem_rd_en` out 1: drives `mem.rd_en`.
- `mem_rd_addr` out ADDRSIZE: drives `mem.rd_addr`.
- `mem_rd_data` in DATA_WIDTH: from `mem.rd_data`, registered in `mem`, valid the cycle after `mem_rd_en`.
- `mem_wr_en` out 1: drives `mem.wr_en`.
- `mem_wr_addr` out ADDRSIZE: drives `mem.wr_addr`.
- `mem_wr_data` out DATA_WIDTH: drives `mem.wr_data`.
- `err` out 1: registered one-cycle pulse on an accepted out-of-range request.

## Operation
- **Read eligible:** `rd_req_valid && (rsp_state==RSP_EMPTY || rd_rsp_ready)`.
- **Write eligible:** `wr_req_valid`. Writes never wait on the response channel.
- **Grant:** at most one grant per cycle. `rd_req_ready` / `wr_req_ready` equal the grant and are combinational from the valids, `rsp_state` and `last_gnt`.
- **Conflict (both eligible):** round-robin. Grant the opposite of `last_gnt`. `last_gnt` updates on every grant and resets to WR, so the first conflict after reset goes to the read.
- **Memory drive:** `mem_*_en`, addresses and write data are combinational from the granted request. `mem_rd_en` and `mem_wr_en` are never both 1.
- **Out-of-range address (addr >= MAX_ADR):** the request is still granted and consumed, but no `mem_*_en` is asserted and `err` pulses in the next cycle. An out-of-range read still produces a response, with data all-zero.
- **Response FSM `rsp_state`:**
  - RSP_EMPTY -> RSP_VALID on a read grant.
  - RSP_VALID -> RSP_EMPTY on `rd_rsp_ready` with no new read grant.
  - RSP_VALID -> RSP_VALID on `rd_rsp_ready` together with a new read grant (back-to-back).
  - `rd_rsp_valid = (rsp_state==RSP_VALID)`.
- **Response data:** `rd_rsp_data = oor_q ? 0 : mem_rd_data`. `mem` holds `rd_data` until its next read, and no new read issues while a response is unaccepted, so the data is stable while `rd_rsp_valid && !rd_rsp_ready`.

## Timing
- Read: request accepted in cycle T, `rd_rsp_valid` in T+1 with data, sustained throughput 1 read/cycle when `rd_rsp_ready=1`.
- Write: accepted in T, `mem_wr_en` in T, memory updated at the T->T+1 edge. A read accepted in T+1 returns the new value.
- `err` rises in T+1 for an out-of-range request accepted in T, and lasts exactly 1 cycle.
- Reset values: `rd_rsp_valid=0`, `err=0`, `rsp_state=RSP_EMPTY`, `last_gnt=WR`, `oor_q=0`. All combinational outputs are 0 when no request is valid.
- Reset mid-operation: a pending response is dropped immediately (async). Accesses already issued to `mem` are not undone.

## Configuration
- `MEM_ARB_WR_PRIO_EN` defined: on conflict, write always wins and `last_gnt` is unused. A read can starve under continuous writes; this is accepted.
- Undefined: round-robin as above. This is the default.

## Structure
- Package `mem_arb_pkg`:
  - Enum `gnt_t {GNT_NONE, GNT_RD, GNT_WR}`.
  - Enum `rsp_state_t {RSP_EMPTY, RSP_VALID}`.
- Sub-module `mem_arb_rr`: 2-way round-robin picker (inputs: two eligibles; output: grant; holds `last_gnt`), bypassed when `MEM_ARB_WR_PRIO_EN` is defined.
- Top-level `mem_arbiter`: eligibility, out-of-range check, response FSM and `mem` drive.

## Test plan
- **Reset:** assert `rst` with random inputs -> `rd_rsp_valid=0`, `err=0`, both `mem_*_en=0` while all valids are 0.
- **Write then read:** write addr 5 data 0xA5, then read addr 5 -> `rd_rsp_valid` the cycle after accept, `rd_rsp_data=0xA5`.
- **Conflict:** read addr 5 and write addr 6 valid together right after reset -> read granted cycle 0, write cycle 1, never both `mem_*_en` high. With `MEM_ARB_WR_PRIO_EN` the write is granted first.
- **Backpressure:** response pending with `rd_rsp_ready=0` for 3 cycles -> `rd_req_ready=0` and `rd_rsp_data` stable, while writes to addr 7 are still granted each cycle.
- **Out of range:** write addr 100 -> `mem_wr_en=0` and `err` 1-cycle pulse. Read addr 127 -> response data 0x00 and `err` pulse.
- **Reset mid-operation:** assert `rst` while `rd_rsp_valid=1` -> `rd_rsp_valid` drops without a clock edge; after release, the first conflict grants the read.
